// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM states, reset cause codes
// and a saturating counter helper.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RUN     = 2'd1,
        WAITREL = 2'd2
    } state_t;

    typedef logic [1:0] cause_t;

    localparam cause_t CAUSE_POR = 2'b00;
    localparam cause_t CAUSE_BTN = 2'b01;
    localparam cause_t CAUSE_SW  = 2'b10;
    localparam cause_t CAUSE_WDT = 2'b11;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/reset_seq_debounce.sv
// Board reset button synchroniser and debouncer; emits single-cycle
// press/release pulses on the cycle the debounced level flips.
module reset_seq_debounce
    import reset_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 24
) (
    input  logic clk,
    input  logic nres,
    input  logic btn_resn,
    output logic btn_press,
    output logic btn_release
);

    logic             sync1;
    logic             sync2;
    logic             db_state;
    logic [CNT_W-1:0] db_cnt;
    logic             db_flip;

    // Flip is combinational so the FSM acts on the same edge as the toggle.
    assign db_flip = (sync2 != db_state) &&
                     (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    assign btn_press   = db_flip & db_state;
    assign btn_release = db_flip & ~db_state;

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            db_state <= 1'b1;
            db_cnt   <= '0;
        end else begin
            sync1 <= btn_resn;
            sync2 <= sync1;
            if (sync2 == db_state) begin
                db_cnt <= '0;
            end else if (db_flip) begin
                db_state <= ~db_state;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer for the Propeller core: POR stretch, button, software
// reboot and watchdog (watchdog only when RESET_SEQ_WDT_EN is defined).
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 24,
    parameter int WDT_CYCLES      = 16777215
) (
    input  logic       clk,
    input  logic       nres,
    input  logic       btn_resn,
    input  logic       cfg_reboot,
    input  logic       wdt_kick,
    output logic       core_nres,
    output logic [1:0] rst_cause,
    output logic [7:0] rst_count
);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] hold_cnt_n;
    cause_t           cause_n;
    logic [7:0]       count_n;
    logic             cfg_q;
    logic             cfg_rise;
    logic             btn_press;
    logic             btn_release;
    logic             wdt_timeout;

    reset_seq_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_debounce (
        .clk        (clk),
        .nres       (nres),
        .btn_resn   (btn_resn),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    assign cfg_rise = cfg_reboot & ~cfg_q;

`ifdef RESET_SEQ_WDT_EN
    logic             wdt_armed;
    logic             wdt_armed_n;
    logic [CNT_W-1:0] wdt_cnt;
    logic [CNT_W-1:0] wdt_cnt_n;

    assign wdt_timeout = wdt_armed && !wdt_kick &&
                         (wdt_cnt == CNT_W'(WDT_CYCLES - 1));

    always_comb begin
        wdt_armed_n = 1'b0;
        wdt_cnt_n   = '0;
        if (state == RUN) begin
            if (wdt_kick) begin
                wdt_armed_n = 1'b1;
            end else if (wdt_armed) begin
                wdt_armed_n = 1'b1;
                wdt_cnt_n   = wdt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            wdt_armed <= 1'b0;
            wdt_cnt   <= '0;
        end else begin
            wdt_armed <= wdt_armed_n;
            wdt_cnt   <= wdt_cnt_n;
        end
    end
`else
    logic unused_wdt;

    assign wdt_timeout = 1'b0;
    assign unused_wdt  = wdt_kick & (WDT_CYCLES != 0);
`endif

    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        cause_n    = rst_cause;
        count_n    = rst_count;
        unique case (state)
            HOLD: begin
                if (btn_press) begin
                    state_n    = WAITREL;
                    hold_cnt_n = '0;
                    cause_n    = CAUSE_BTN;
                    count_n    = sat_inc8(rst_count);
                end else if (hold_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_n    = RUN;
                    hold_cnt_n = '0;
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            RUN: begin
                hold_cnt_n = '0;
                if (btn_press) begin
                    state_n = WAITREL;
                    cause_n = CAUSE_BTN;
                    count_n = sat_inc8(rst_count);
                end else if (cfg_rise) begin
                    state_n = HOLD;
                    cause_n = CAUSE_SW;
                    count_n = sat_inc8(rst_count);
                end else if (wdt_timeout) begin
                    state_n = HOLD;
                    cause_n = CAUSE_WDT;
                    count_n = sat_inc8(rst_count);
                end
            end
            WAITREL: begin
                hold_cnt_n = '0;
                if (btn_release) begin
                    state_n = HOLD;
                end
            end
            default: begin
                state_n    = HOLD;
                hold_cnt_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            core_nres <= 1'b0;
            rst_cause <= CAUSE_POR;
            rst_count <= 8'd0;
            cfg_q     <= 1'b0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_cnt_n;
            core_nres <= (state_n == RUN);
            rst_cause <= cause_n;
            rst_count <= count_n;
            cfg_q     <= cfg_reboot;
        end
    end

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: stimulus queues expected core_nres
// edges, a monitor pops and checks each observed edge.
module tb_reset_seq;
    import reset_seq_pkg::*;

    localparam int HOLD = 4;
    localparam int DB   = 8;
    localparam int WDT  = 32;

    logic       clk        = 1'b0;
    logic       nres       = 1'b1;
    logic       btn_resn   = 1'b1;
    logic       cfg_reboot = 1'b0;
    logic       wdt_kick   = 1'b0;
    logic       core_nres;
    logic [1:0] rst_cause;
    logic [7:0] rst_count;

    reset_seq #(
        .HOLD_CYCLES    (HOLD),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (24),
        .WDT_CYCLES     (WDT)
    ) dut (
        .clk       (clk),
        .nres      (nres),
        .btn_resn  (btn_resn),
        .cfg_reboot(cfg_reboot),
        .wdt_kick  (wdt_kick),
        .core_nres (core_nres),
        .rst_cause (rst_cause),
        .rst_count (rst_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic       lvl;
        int         at;
        logic [1:0] cause;
        int         count;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   mcount = 0;
    logic prev   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (core_nres !== prev) begin
            exp_t e;
            prev = core_nres;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_edge: core_nres went %b at cycle %0d, none expected",
                         core_nres, cyc);
            end else begin
                e = sb.pop_front();
                chk("edge_level", int'(core_nres), int'(e.lvl));
                chk("edge_cycle", cyc, e.at);
                chk("edge_cause", int'(rst_cause), int'(e.cause));
                chk("edge_count", int'(rst_count), e.count);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic lvl, input int at,
                        input logic [1:0] c, input int n);
        exp_t e;
        e.lvl   = lvl;
        e.at    = at;
        e.cause = c;
        e.count = n;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget, input string name);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    task automatic kick();
        wdt_kick = 1'b1;
        tick();
        wdt_kick = 1'b0;
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    initial begin
        int n0;
        #1 nres = 1'b0;
        repeat (3) tick();
        chk("por_core_nres", int'(core_nres), 0);
        chk("por_cause", int'(rst_cause), 0);
        chk("por_count", int'(rst_count), 0);
        push(1'b1, cyc + HOLD, CAUSE_POR, 0);
        nres = 1'b1;
        drain(20, "por_drain");
        chk("por_run", int'(core_nres), 1);

        for (int i = 0; i < 10; i++) begin
            btn_resn = ~btn_resn;
            repeat (3) tick();
        end
        chk("bounce_no_reset", int'(core_nres), 1);

        mcount = 1;
        push(1'b0, cyc + 2 + DB, CAUSE_BTN, mcount);
        btn_resn = 1'b0;
        repeat (20) tick();
        chk("press_held_low", int'(core_nres), 0);
        drain(5, "press_drain");

        push(1'b1, cyc + 2 + DB + HOLD, CAUSE_BTN, mcount);
        btn_resn = 1'b1;
        drain(30, "release_drain");

        mcount = 2;
        push(1'b0, cyc + 1, CAUSE_SW, mcount);
        push(1'b1, cyc + 1 + HOLD, CAUSE_SW, mcount);
        cfg_reboot = 1'b1;
        repeat (20) tick();
        cfg_reboot = 1'b0;
        drain(5, "sw_drain");
        chk("sw_count", int'(rst_count), 2);

        tick();
        n0 = cyc;
        btn_resn = 1'b0;
        repeat (2 + DB - 1) tick();
        mcount = 3;
        push(1'b0, n0 + 2 + DB, CAUSE_BTN, mcount);
        cfg_reboot = 1'b1;
        repeat (5) tick();
        cfg_reboot = 1'b0;
        chk("prio_cause", int'(rst_cause), int'(CAUSE_BTN));
        chk("prio_count", int'(rst_count), 3);
        push(1'b1, cyc + 2 + DB + HOLD, CAUSE_BTN, mcount);
        btn_resn = 1'b1;
        drain(30, "prio_drain");

        for (int i = 0; i < 300; i++) begin
            tick();
            mcount = sat(mcount + 1);
            push(1'b0, cyc + 1, CAUSE_SW, mcount);
            push(1'b1, cyc + 1 + HOLD, CAUSE_SW, mcount);
            cfg_reboot = 1'b1;
            tick();
            cfg_reboot = 1'b0;
            drain(10, "reboot_drain");
        end
        chk("sat_count", int'(rst_count), 255);

        kick();
        for (int i = 0; i < 5; i++) begin
            repeat (19) tick();
            kick();
        end
        chk("kicked_no_reset", int'(core_nres), 1);
`ifdef RESET_SEQ_WDT_EN
        push(1'b0, cyc + WDT, CAUSE_WDT, 255);
        push(1'b1, cyc + WDT + HOLD, CAUSE_WDT, 255);
        drain(60, "wdt_drain");
`else
        repeat (60) tick();
        chk("no_wdt_reset", int'(core_nres), 1);
`endif
        repeat (80) tick();
        chk("idle_no_reset", int'(core_nres), 1);
`ifdef RESET_SEQ_WDT_EN
        chk("idle_cause", int'(rst_cause), int'(CAUSE_WDT));
`else
        chk("idle_cause", int'(rst_cause), int'(CAUSE_SW));
`endif

        push(1'b0, cyc + 1, CAUSE_POR, 0);
        nres = 1'b0;
        #1;
        chk("async_core_nres", int'(core_nres), 0);
        chk("async_count", int'(rst_count), 0);
        tick();
        tick();
        push(1'b1, cyc + HOLD, CAUSE_POR, 0);
        nres = 1'b1;
        drain(20, "async_drain");
        chk("final_cause", int'(rst_cause), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
